// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch front end: key FSM states, default button count
// and the button bit positions used by the debouncer and key event generator.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_LONG  = 2'd2
  } key_state_t;

  localparam int N_BTN_DEF = 6;

  localparam int BTN_S0  = 0;
  localparam int BTN_S1  = 1;
  localparam int BTN_S2  = 2;
  localparam int BTN_S3  = 3;
  localparam int BTN_S4  = 4;
  localparam int BTN_SW7 = 5;

endpackage

// File: rtl/key_fsm.sv
// Per-button event FSM: turns synchronised rise/fall strobes plus the tick timebase into
// registered press / release / long-press / auto-repeat pulses and a held flag.
module key_fsm
  import stopwatch_pkg::*;
#(
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200,
  parameter int CNT_W        = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic rise_i,
  input  logic fall_i,
  input  logic arm_i,
  input  logic repeat_en_i,
  output logic press_evt_o,
  output logic rel_evt_o,
  output logic long_evt_o,
  output logic rpt_evt_o,
  output logic held_o
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_TICKS - 1);

  key_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             long_q, long_d;
  logic             rpt_q, rpt_d;
  logic             held_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    armed_d = armed_q | arm_i;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    rpt_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rise_i && armed_q) begin
          state_d = ST_PRESS;
          press_d = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_PRESS: begin
        // A fall always beats a tick landing on the terminal count.
        if (fall_i) begin
          state_d = ST_IDLE;
          rel_d   = 1'b1;
          cnt_d   = '0;
        end else if (tick_i) begin
          if (cnt_q == LONG_LAST) begin
            state_d = ST_LONG;
            long_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_LONG: begin
        if (fall_i) begin
          state_d = ST_IDLE;
          rel_d   = 1'b1;
          cnt_d   = '0;
        end else if (!repeat_en_i) begin
          cnt_d = '0;
        end else if (tick_i) begin
          if (cnt_q == RPT_LAST) begin
            rpt_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      rpt_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      rpt_q   <= rpt_d;
      held_q  <= (state_d != ST_IDLE);
    end
  end

  assign press_evt_o = press_q;
  assign rel_evt_o   = rel_q;
  assign long_evt_o  = long_q;
  assign rpt_evt_o   = rpt_q;
  assign held_o      = held_q;

endmodule

// File: rtl/key_event_gen.sv
// Synchronises debounced button levels into clk, detects edges and fans them out to one
// key_fsm per button, which produce single-cycle key events.
module key_event_gen
  import stopwatch_pkg::*;
#(
  parameter int N_BTN        = N_BTN_DEF,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200,
  parameter int CNT_W        = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [N_BTN-1:0] btn_lvl,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] press_evt,
  output logic [N_BTN-1:0] rel_evt,
  output logic [N_BTN-1:0] long_evt,
  output logic [N_BTN-1:0] rpt_evt,
  output logic [N_BTN-1:0] held
);

  logic [N_BTN-1:0] sync_meta_q;
  logic [N_BTN-1:0] lvl_s_q;
  logic [N_BTN-1:0] lvl_prev_q;
  logic [1:0]       sync_vld_q;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;
  logic [N_BTN-1:0] arm;

  // sync_vld_q marks when lvl_s_q holds a real sample rather than its reset zero,
  // so a button held through reset cannot arm itself from the flushed pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_q <= '0;
      lvl_s_q     <= '0;
      lvl_prev_q  <= '0;
      sync_vld_q  <= '0;
    end else begin
      sync_meta_q <= btn_lvl;
      lvl_s_q     <= sync_meta_q;
      lvl_prev_q  <= lvl_s_q;
      sync_vld_q  <= {sync_vld_q[0], 1'b1};
    end
  end

  assign rise = lvl_s_q & ~lvl_prev_q;
  assign fall = ~lvl_s_q & lvl_prev_q;
  assign arm  = {N_BTN{sync_vld_q[1]}} & ~lvl_s_q;

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_key
      key_fsm #(
        .LONG_TICKS  (LONG_TICKS),
        .REPEAT_TICKS(REPEAT_TICKS),
        .CNT_W       (CNT_W)
      ) u_key_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_i     (tick),
        .rise_i     (rise[gi]),
        .fall_i     (fall[gi]),
        .arm_i      (arm[gi]),
        .repeat_en_i(repeat_en[gi]),
        .press_evt_o(press_evt[gi]),
        .rel_evt_o  (rel_evt[gi]),
        .long_evt_o (long_evt[gi]),
        .rpt_evt_o  (rpt_evt[gi]),
        .held_o     (held[gi])
      );
    end
  endgenerate

endmodule
